// File: rtl/snoop_bus_arbiter_if.sv
// Shared snooping-bus signal bundle between the cache controllers and the
// bus arbiter/sequencer.
//   slave  : arbiter side  (requests and snoop responses in; grant, address
//            phase, completion and status out)
//   master : requester side (mirror of slave)
interface snoop_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      req_cmd;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        snoop_hit;
    logic [NUM_REQ-1:0]        snoop_hitm;
    logic [NUM_REQ-1:0]        gnt;
    logic                      bus_valid;
    logic [1:0]                bus_cmd;
    logic [ADDR_W-1:0]         bus_addr;
    logic [SRC_W-1:0]          bus_src;
    logic [NUM_REQ-1:0]        done;
    logic                      resp_shared;
    logic                      resp_from_cache;
    logic                      err;
    logic                      busy;

    modport slave (
        input  req, req_cmd, req_addr, snoop_hit, snoop_hitm,
        output gnt, bus_valid, bus_cmd, bus_addr, bus_src, done,
               resp_shared, resp_from_cache, err, busy
    );

    modport master (
        output req, req_cmd, req_addr, snoop_hit, snoop_hitm,
        input  gnt, bus_valid, bus_cmd, bus_addr, bus_src, done,
               resp_shared, resp_from_cache, err, busy
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the MESI snooping bus.
// Grants one requester at a time, broadcasts its address phase, gathers snoop
// responses from the other caches, models data-phase latency and returns a
// one-cycle completion carrying the shared / cache-supplied / error result.
//   clk_i    : clock, rising edge
//   reset_ni : asynchronous active-low reset
//   bus_if   : snoop_bus_arbiter_if.slave (requests, snoops, grant, bus, done)
module snoop_bus_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SNOOP_WAIT = 2,
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned C2C_LAT    = 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    snoop_bus_arbiter_if.slave  bus_if
);
    localparam int unsigned SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W    = 16;
    localparam logic [1:0]  CMD_UPGR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SNOOP,
        S_DATA,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    rr_q, rr_d;
    logic [SRC_W-1:0]    win_q, win_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic                hitm_q, hitm_d;
    logic                valid_q, valid_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                shared_q, shared_d;
    logic                from_cache_q, from_cache_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]   elig;
    logic [2*NUM_REQ-1:0] rot2;
    logic                 found;
    logic [SRC_W-1:0]     pick;
    logic [1:0]           cmd_sel;
    logic [ADDR_W-1:0]    addr_sel;
    logic                 snp_hit, snp_hitm;

    // Eligible = requesting with a real command.
    always_comb begin : eligibility
        elig = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            elig[i] = bus_if.req[i] && (bus_if.req_cmd[2*i +: 2] != 2'b00);
        end
    end

    // Rotate so bit 0 is rr_q; lowest set bit after rotation is the winner.
    always_comb begin : arbitrate
        found = 1'b0;
        pick  = '0;
        rot2  = {elig, elig} >> rr_q;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rot2[k]) begin
                found = 1'b1;
                pick  = SRC_W'((32'(rr_q) + 32'(k)) % NUM_REQ);
            end
        end
        cmd_sel  = '0;
        addr_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick == SRC_W'(i)) begin
                cmd_sel  = bus_if.req_cmd[2*i +: 2];
                addr_sel = bus_if.req_addr[i*int'(ADDR_W) +: ADDR_W];
            end
        end
    end

    // Snoop flags including this cycle's inputs; the winner's own bit is
    // masked through its grant bit.
    assign snp_hit  = hit_q  | (|(bus_if.snoop_hit  & ~gnt_q));
    assign snp_hitm = hitm_q | (|(bus_if.snoop_hitm & ~gnt_q));

    // Next state and registered-output values.
    always_comb begin : fsm_next
        state_d      = state_q;
        rr_d         = rr_q;
        win_d        = win_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        hitm_d       = hitm_q;
        valid_d      = 1'b0;
        done_d       = '0;
        shared_d     = 1'b0;
        from_cache_d = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    cmd_d   = cmd_sel;
                    addr_d  = addr_sel;
                    gnt_d   = NUM_REQ'(1) << pick;
                    valid_d = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                hit_d   = 1'b0;
                hitm_d  = 1'b0;
                cnt_d   = CNT_W'(SNOOP_WAIT - 1);
                state_d = S_SNOOP;
            end
            S_SNOOP: begin
                hit_d  = snp_hit;
                hitm_d = snp_hitm;
                if (cnt_q == '0) begin
                    if (cmd_q == CMD_UPGR) begin
                        // Upgrade carries no data; an M copy elsewhere is a protocol error.
                        state_d      = S_DONE;
                        done_d       = gnt_q;
                        shared_d     = snp_hit | snp_hitm;
                        from_cache_d = snp_hitm;
                        err_d        = snp_hitm;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = snp_hitm ? CNT_W'(C2C_LAT - 1) : CNT_W'(MEM_LAT - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    state_d      = S_DONE;
                    done_d       = gnt_q;
                    shared_d     = hit_q | hitm_q;
                    from_cache_d = hitm_q;
                    err_d        = (cmd_q == CMD_UPGR) & hitm_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                rr_d    = (win_q == SRC_W'(NUM_REQ - 1)) ? '0 : win_q + SRC_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            win_q        <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            hit_q        <= 1'b0;
            hitm_q       <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= '0;
            shared_q     <= 1'b0;
            from_cache_q <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            win_q        <= win_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            hitm_q       <= hitm_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            shared_q     <= shared_d;
            from_cache_q <= from_cache_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus_if.gnt             = gnt_q;
    assign bus_if.bus_valid       = valid_q;
    assign bus_if.bus_cmd         = cmd_q;
    assign bus_if.bus_addr        = addr_q;
    assign bus_if.bus_src         = win_q;
    assign bus_if.done            = done_q;
    assign bus_if.resp_shared     = shared_q;
    assign bus_if.resp_from_cache = from_cache_q;
    assign bus_if.err             = err_q;
    assign bus_if.busy            = busy_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Randomized and directed bench for snoop_bus_arbiter against a
// transaction-level reference model.
module tb_snoop_bus_arbiter;
    localparam int unsigned N     = 4;
    localparam int unsigned AW    = 32;
    localparam int          SW    = 2;
    localparam int          MEM   = 4;
    localparam int          C2C   = 1;

    logic clk;
    logic reset_ni;

    snoop_bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW)) bus_if ();

    snoop_bus_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .SNOOP_WAIT(SW), .MEM_LAT(MEM), .C2C_LAT(C2C)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .bus_if  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side stimulus
    logic [N-1:0]  nxt_req, nxt_hit, nxt_hitm;
    logic [1:0]    nxt_cmd  [N];
    logic [AW-1:0] nxt_addr [N];
    bit            rand_mode;

    // Reference model state (transaction level, edge-numbered)
    int            e;
    bit            m_active;
    int            m_win, m_rr, m_start, m_done_edge, m_next_free;
    logic [1:0]    m_cmd;
    logic [AW-1:0] m_addr;
    bit            m_hit, m_hitm;

    // Expected outputs after the current edge
    logic [N-1:0]  x_gnt, x_done;
    bit            x_valid, x_busy, x_shared, x_fc, x_err;

    // Observations for directed latency / order checks
    int            obs_valid_e, obs_lat;
    logic [2:0]    obs_flags;
    int            dut_order[$];

    int            n_checks, n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive();
        logic [2*N-1:0]  c;
        logic [N*AW-1:0] a;
        c = '0;
        a = '0;
        for (int i = 0; i < int'(N); i++) begin
            c[2*i +: 2]   = nxt_cmd[i];
            a[i*AW +: AW] = nxt_addr[i];
        end
        bus_if.req        = nxt_req;
        bus_if.req_cmd    = c;
        bus_if.req_addr   = a;
        bus_if.snoop_hit  = nxt_hit;
        bus_if.snoop_hitm = nxt_hitm;
    endtask

    // Predicts outputs after the next rising edge from the inputs just driven.
    task automatic model_edge();
        logic [N-1:0] oh;
        bit           got;
        x_gnt = '0; x_done = '0; x_valid = 0; x_busy = 0;
        x_shared = 0; x_fc = 0; x_err = 0;
        e++;
        if (!reset_ni) begin
            m_active = 0; m_rr = 0; m_next_free = 0;
            return;
        end
        if (!m_active && e >= m_next_free) begin
            got = 0;
            for (int k = 0; k < int'(N); k++) begin
                int j;
                j = (m_rr + k) % int'(N);
                if (!got && nxt_req[j] && nxt_cmd[j] != 2'b00) begin
                    got = 1;
                    m_active = 1; m_win = j; m_cmd = nxt_cmd[j]; m_addr = nxt_addr[j];
                    m_start = e; m_done_edge = -1; m_hit = 0; m_hitm = 0;
                end
            end
        end
        if (m_active) begin
            oh = N'(1) << m_win;
            x_gnt = oh;
            x_busy = 1;
            if (e == m_start) x_valid = 1;
            if (e >= m_start + 2 && e <= m_start + 1 + SW) begin
                m_hit  = m_hit  | (|(nxt_hit  & ~oh));
                m_hitm = m_hitm | (|(nxt_hitm & ~oh));
                if (e == m_start + 1 + SW)
                    m_done_edge = (m_cmd == 2'b11) ? e : e + (m_hitm ? C2C : MEM);
            end
            if (e == m_done_edge) begin
                x_done   = oh;
                x_shared = m_hit | m_hitm;
                x_fc     = m_hitm;
                x_err    = (m_cmd == 2'b11) && m_hitm;
                m_active = 0;
                m_rr = (m_win + 1) % int'(N);
                m_next_free = e + 2;
                nxt_req[m_win] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        if (bus_if.bus_valid) begin
            obs_valid_e = e;
            dut_order.push_back(int'(bus_if.bus_src));
        end
        if (|bus_if.done) begin
            obs_lat   = e - obs_valid_e + 1;
            obs_flags = {bus_if.resp_shared, bus_if.resp_from_cache, bus_if.err};
        end
        check("gnt",        64'(bus_if.gnt),             64'(x_gnt));
        check("bus_valid",  64'(bus_if.bus_valid),       64'(x_valid));
        check("busy",       64'(bus_if.busy),            64'(x_busy));
        check("done",       64'(bus_if.done),            64'(x_done));
        check("resp_shared",64'(bus_if.resp_shared),     64'(x_shared));
        check("resp_cache", 64'(bus_if.resp_from_cache), 64'(x_fc));
        check("err",        64'(bus_if.err),             64'(x_err));
        if (x_valid) begin
            check("bus_cmd",  64'(bus_if.bus_cmd),  64'(m_cmd));
            check("bus_addr", 64'(bus_if.bus_addr), 64'(m_addr));
            check("bus_src",  64'(bus_if.bus_src),  64'(m_win));
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < int'(N); i++) begin
            if (!nxt_req[i]) begin
                if ($urandom_range(0, 5) == 0) begin
                    nxt_req[i]  = 1'b1;
                    nxt_cmd[i]  = 2'($urandom_range(0, 3));
                    nxt_addr[i] = $urandom;
                end
            end else if (nxt_cmd[i] == 2'b00 && $urandom_range(0, 3) == 0) begin
                nxt_req[i] = 1'b0;
            end else if ($urandom_range(0, 63) == 0) begin
                nxt_req[i] = 1'b0;
            end
        end
        nxt_hit  = N'($urandom) & N'($urandom);
        nxt_hitm = N'($urandom) & N'($urandom) & N'($urandom);
    endtask

    task automatic cycle();
        if (rand_mode) randomize_inputs();
        drive();
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while ((nxt_req != '0 || m_active) && n < max_cycles) begin
            cycle();
            n++;
        end
        check("timeout", 64'(n < max_cycles), 64'(1));
    endtask

    task automatic reset_outputs_zero(input string tag);
        check(tag, 64'({bus_if.gnt, bus_if.bus_valid, bus_if.bus_cmd, bus_if.bus_addr,
                        bus_if.bus_src, bus_if.done, bus_if.resp_shared,
                        bus_if.resp_from_cache, bus_if.err, bus_if.busy}), 64'(0));
    endtask

    task automatic pulse_reset();
        reset_ni = 1'b0;
        #1;
        reset_outputs_zero("reset_outputs");
        cycle();
        reset_ni = 1'b1;
    endtask

    task automatic one_req(input int idx, input logic [1:0] cmd, input logic [AW-1:0] addr,
                           input logic [N-1:0] hit, input logic [N-1:0] hitm,
                           input int exp_lat, input logic [2:0] exp_flags, input string tag);
        nxt_req[idx] = 1'b1; nxt_cmd[idx] = cmd; nxt_addr[idx] = addr;
        nxt_hit = hit; nxt_hitm = hitm;
        obs_lat = -1; obs_flags = 3'bxxx;
        run_until_idle(60);
        nxt_hit = '0; nxt_hitm = '0;
        check({tag, "_lat"},   64'(obs_lat),   64'(exp_lat));
        check({tag, "_flags"}, 64'(obs_flags), 64'(exp_flags));
    endtask

    initial begin
        n_checks = 0; n_errors = 0; rand_mode = 0;
        e = 0; m_active = 0; m_rr = 0; m_next_free = 0; m_done_edge = -1;
        obs_valid_e = 0; obs_lat = -1; obs_flags = '0;
        nxt_req = '0; nxt_hit = '0; nxt_hitm = '0;
        for (int i = 0; i < int'(N); i++) begin nxt_cmd[i] = '0; nxt_addr[i] = '0; end
        drive();
        reset_ni = 1'b1;
        #1 reset_ni = 1'b0;
        repeat (2) @(negedge clk);
        reset_outputs_zero("reset_state");
        reset_ni = 1'b1;

        // Single BusRd from memory, no snoop hits
        one_req(1, 2'b01, 32'h0000_1000, '0, '0, 8, 3'b000, "rd_mem");

        // Fresh pointer, then two-way and four-way round robin
        pulse_reset();
        dut_order.delete();
        nxt_req = 4'b0101; nxt_cmd[0] = 2'b01; nxt_cmd[2] = 2'b01;
        nxt_addr[0] = 32'h0000_2000; nxt_addr[2] = 32'h0000_2040;
        run_until_idle(60);
        for (int i = 0; i < int'(N); i++) begin nxt_cmd[i] = 2'b01; nxt_addr[i] = 32'h3000 + 32'(i*64); end
        nxt_req = 4'b1111;
        run_until_idle(120);
        check("rr_count", 64'(dut_order.size()), 64'(6));
        if (dut_order.size() == 6) begin
            check("rr_0", 64'(dut_order[0]), 64'(0));
            check("rr_1", 64'(dut_order[1]), 64'(2));
            check("rr_2", 64'(dut_order[2]), 64'(3));
            check("rr_3", 64'(dut_order[3]), 64'(0));
            check("rr_4", 64'(dut_order[4]), 64'(1));
            check("rr_5", 64'(dut_order[5]), 64'(2));
        end

        // Cache-to-cache, upgrades, own-bit masking
        one_req(0, 2'b10, 32'h0000_4000, 4'b0000, 4'b1000, 5, 3'b110, "rdx_c2c");
        one_req(2, 2'b11, 32'h0000_5000, 4'b0010, 4'b0000, 4, 3'b100, "upgr_hit");
        one_req(2, 2'b11, 32'h0000_5000, 4'b0000, 4'b0010, 4, 3'b111, "upgr_hitm");
        one_req(1, 2'b01, 32'h0000_6000, 4'b0000, 4'b0010, 8, 3'b000, "own_mask");
        one_req(3, 2'b01, 32'h0000_7000, 4'b0001, 4'b0001, 5, 3'b110, "hit_and_hitm");

        // Reset in the middle of a snoop phase
        nxt_req = 4'b0100; nxt_cmd[2] = 2'b01; nxt_addr[2] = 32'h0000_8000;
        begin
            int n;
            n = 0;
            while (!(m_active && e == m_start + 2) && n < 20) begin cycle(); n++; end
            check("reach_snoop", 64'(n < 20), 64'(1));
        end
        #2 reset_ni = 1'b0;
        #1 reset_outputs_zero("reset_abort");
        cycle();
        cycle();
        reset_ni = 1'b1;
        dut_order.delete();
        nxt_req[0] = 1'b1; nxt_cmd[0] = 2'b01; nxt_addr[0] = 32'h0000_9000;
        run_until_idle(60);
        check("post_rst_count", 64'(dut_order.size()), 64'(2));
        if (dut_order.size() > 0) check("post_rst_first", 64'(dut_order[0]), 64'(0));

        // Random traffic
        rand_mode = 1;
        repeat (3000) cycle();
        rand_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared snooping bus in the MESI cache simulator.
- Takes bus requests (BusRd, BusRdX, BusUpgr) from NUM_REQ cache controllers and grants the bus to one requester at a time.
- For the granted request: broadcasts the address phase, collects snoop responses from the other caches, models data-phase latency, and returns a completion pulse. The completion carries the shared/modified result that the requesting cache's MESI FSM uses to choose its next state.

Parameters:
- NUM_REQ, 4, number of cache controllers on the bus (2..8).
- ADDR_W, 32, bus address width.
- SNOOP_WAIT, 2, cycles spent collecting snoop responses (>=1).
- MEM_LAT, 4, data-phase cycles when memory supplies the line (>=1).
- C2C_LAT, 1, data-phase cycles when a cache supplies a modified line (>=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester bus request; held until that requester's done.
- req_cmd  in  2*NUM_REQ  per-requester command: 00 none, 01 BusRd, 10 BusRdX, 11 BusUpgr.
- req_addr  in  NUM_REQ*ADDR_W  per-requester line address.
- snoop_hit  in  NUM_REQ  snooper holds the line in S or E.
- snoop_hitm  in  NUM_REQ  snooper holds the line in M.
- gnt  out  NUM_REQ  one-hot grant, held from arbitration through DONE.
- bus_valid  out  1  address phase strobe, one cycle.
- bus_cmd  out  2  latched command; valid while bus_valid.
- bus_addr  out  ADDR_W  latched address; valid while bus_valid.
- bus_src  out  clog2(NUM_REQ)  index of the granted requester.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- resp_shared  out  1  valid with done: some other cache had hit or hitm.
- resp_from_cache  out  1  valid with done: line supplied by a cache (hitm seen).
- err  out  1  valid with done: BusUpgr saw a hitm (illegal under MESI).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: gnt, bus_valid, bus_cmd, bus_addr, bus_src, done, resp_*, err, busy.
  - Accumulated snoop flags cleared.
- Eligibility: requester i is eligible when req[i]=1 and its cmd != 00.
- IDLE:
  - If any requester is eligible, pick the first one scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Latch its cmd, addr and index; set gnt one-hot; go to ADDR.
  - No eligible requester: stay in IDLE.
- ADDR (1 cycle): bus_valid=1, bus_cmd/bus_addr/bus_src driven from the latch. Go to SNOOP and clear the snoop accumulators.
- SNOOP (SNOOP_WAIT cycles):
  - Each cycle, OR snoop_hit and snoop_hitm into the accumulators, with the winner's own bit masked off.
  - On exit:
    - cmd BusUpgr → DONE directly (no data phase).
    - hitm accumulated → DATA with count C2C_LAT.
    - otherwise → DATA with count MEM_LAT.
- DATA: down-counter loaded with the selected latency; go to DONE when the count expires.
- DONE (1 cycle):
  - done[winner]=1.
  - resp_shared = hit_acc | hitm_acc.
  - resp_from_cache = hitm_acc.
  - err = (cmd==BusUpgr) & hitm_acc.
  - Then gnt=0, rr_ptr = winner+1 (mod NUM_REQ), go to IDLE.
- done, resp_*, err are 0 in every other state.
- Latency, in edges counted from the edge that samples req in IDLE to the edge after which done is high:
  - Upgr: 2+SNOOP_WAIT.
  - Data transfer: 2+SNOOP_WAIT+lat.
  - Defaults: Upgr 4, C2C 5, memory 8.
- Back-to-back transactions: minimum one IDLE cycle between DONE and the next grant.
- Boundary cases:
  - Winner drops req mid-transaction: the transaction still completes and done still pulses.
  - Snoop inputs outside SNOOP are ignored.
  - hit and hitm both asserted: both flags set; resp_from_cache=1.
  - Requests arriving while busy wait in line; nothing is queued beyond the held req level.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset asserted in any state aborts immediately, with no done pulse.

Test Plan:
- Req1 BusRd addr 0x1000, no snoops → gnt=0010 after edge 1, bus_valid one cycle with cmd 01, addr 0x1000, src 1; done[1] after edge 8; resp_shared=0, resp_from_cache=0.
- Req0 and req2 assert BusRd together → req0 served first, req2 next; then all four request → order 3,0,1,2.
- Req0 BusRdX while snoop_hitm[3]=1 in SNOOP → done[0] after edge 5; resp_from_cache=1, resp_shared=1.
- Req2 BusUpgr:
  - With snoop_hit[1] → done[2] after edge 4, resp_shared=1, err=0.
  - Repeated with snoop_hitm[1] → err=1.
- Req1 BusRd with snoop_hitm[1]=1 only (own bit) → masked; resp_shared=0, memory latency 8.
- Reset pulled low during SNOOP of req2 → all outputs 0 at once, no done; after release with req0 and req2 pending, req0 is granted first (rr_ptr=0).
